// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative unsigned multiply/divide unit for the EX stage
// One shift-add or restoring-divide step per cycle; 32 steps per operation.
module mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            EN,
   input  logic            start_in,
   input  logic [1:0]      op_in,
   input  logic [XLEN-1:0] opA_in,
   input  logic [XLEN-1:0] opB_in,
   input  logic            flush_in,
   output logic            stall_out,
   output logic            busy_out,
   output logic            done_out,
   output logic [XLEN-1:0] result_out
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nx;
   logic [1:0]      op_q;
   logic [XLEN-1:0] opnd_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [5:0]      cnt_q;
   logic            div_zero;
   logic            accept;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_trial;

   assign div_zero = op_in[1] && (opB_in == '0);
   assign accept   = (state == IDLE) && start_in && !flush_in;

   // hi:lo is the product for multiplies and remainder:quotient for divides
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         state <= IDLE;
      else if (EN)
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush_in)
         state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (start_in) state_nx = div_zero ? DONE : CALC;
            CALC:    if (cnt_q == 6'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         op_q   <= '0;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
      end else if (EN && !flush_in) begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  op_q   <= op_in;
                  cnt_q  <= '0;
                  opnd_q <= op_in[1] ? opB_in : opA_in;
                  // divide by zero preloads the architectural results directly
                  hi_q   <= div_zero ? opA_in : '0;
                  lo_q   <= div_zero ? '1 : (op_in[1] ? opA_in : opB_in);
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 6'd1;
               if (!op_q[1]) begin
                  hi_q <= mul_sum[XLEN:1];
                  lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
               end else if (!div_trial[XLEN]) begin
                  hi_q <= div_trial[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                  lo_q <= {lo_q[XLEN-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_out   = (state == CALC);
      done_out   = (state == DONE) && !flush_in;
      stall_out  = RSTn && (accept || (state == CALC));
      result_out = '0;
      if (done_out)
         result_out = op_q[0] ? hi_q : lo_q;
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized self-checking bench for mdu_seq
// Results are compared against plain 64-bit arithmetic and a cycle-count model.
module tb_mdu_seq;

   logic        CLK;
   logic        RSTn;
   logic        EN;
   logic        start_in;
   logic [1:0]  op_in;
   logic [31:0] opA_in;
   logic [31:0] opB_in;
   logic        flush_in;
   logic        stall_out;
   logic        busy_out;
   logic        done_out;
   logic [31:0] result_out;

   int n_chk  = 0;
   int n_pass = 0;

   mdu_seq #(.XLEN(32)) dut (
      .CLK(CLK), .RSTn(RSTn), .EN(EN), .start_in(start_in), .op_in(op_in),
      .opA_in(opA_in), .opB_in(opB_in), .flush_in(flush_in),
      .stall_out(stall_out), .busy_out(busy_out), .done_out(done_out),
      .result_out(result_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // pause_at>0 drops EN for 5 edges after that many edges; hold_done freezes in DONE
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int pause_at, input bit hold_done);
      int n, bad, exp_lat;
      bit got;
      logic [31:0] exp_res;
      exp_res = ref_result(op, a, b);
      exp_lat = (op[1] && b == 0) ? 1 : 33 + ((pause_at > 0) ? 5 : 0);
      @(negedge CLK);
      start_in = 1'b1; op_in = op; opA_in = a; opB_in = b;
      #1;
      chk("stall_at_accept", stall_out, 1'b1);
      n = 0; bad = 0; got = 0;
      while (n < 80 && !got) begin
         @(posedge CLK); #1;
         n++;
         if (done_out) got = 1;
         else if (!busy_out || !stall_out) bad++;
         if (pause_at > 0 && n == pause_at) EN = 1'b0;
         if (pause_at > 0 && n == pause_at + 5) EN = 1'b1;
      end
      start_in = 1'b0;
      chk("latency", n, exp_lat);
      chk("busy_stall_in_calc", bad, 0);
      chk("result", result_out, exp_res);
      chk("busy_in_done", busy_out, 1'b0);
      chk("stall_in_done", stall_out, 1'b0);
      if (hold_done) begin
         EN = 1'b0;
         repeat (2) @(posedge CLK);
         #1;
         chk("done_frozen", done_out, 1'b1);
         chk("result_frozen", result_out, exp_res);
         EN = 1'b1;
      end
      @(posedge CLK); #1;
      chk("done_drops", done_out, 1'b0);
      chk("result_zero_after", result_out, 32'd0);
   endtask

   task automatic count_done(input int cycles, output int seen);
      seen = 0;
      repeat (cycles) begin
         @(posedge CLK); #1;
         if (done_out) seen++;
      end
   endtask

   initial begin
      int seen;
      logic [1:0] op;
      logic [31:0] a, b;
      RSTn = 1'b0; EN = 1'b1; start_in = 1'b1; op_in = 2'd0;
      opA_in = 32'd5; opB_in = 32'd3; flush_in = 1'b0;
      #12;
      chk("rst_stall", stall_out, 1'b0);
      chk("rst_busy", busy_out, 1'b0);
      chk("rst_done", done_out, 1'b0);
      chk("rst_result", result_out, 32'd0);
      start_in = 1'b0;
      @(negedge CLK); RSTn = 1'b1;

      run_op(2'd0, 32'd7, 32'd6, 0, 0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(2'd2, 32'd100, 32'd7, 0, 0);
      run_op(2'd3, 32'd100, 32'd7, 0, 0);
      run_op(2'd2, 32'h1234, 32'd0, 0, 0);
      run_op(2'd3, 32'h1234, 32'd0, 0, 1);
      run_op(2'd2, 32'hFFFF_FFFF, 32'd1, 0, 0);

      // flush after 10 iterations aborts without a result
      @(negedge CLK);
      start_in = 1'b1; op_in = 2'd0; opA_in = 32'd9; opB_in = 32'd9;
      repeat (11) @(posedge CLK);
      #1; flush_in = 1'b1;
      @(posedge CLK); #1;
      chk("flush_busy", busy_out, 1'b0);
      chk("flush_stall", stall_out, 1'b0);
      chk("flush_done", done_out, 1'b0);
      flush_in = 1'b0; start_in = 1'b0;
      count_done(40, seen);
      chk("flush_no_done", seen, 0);
      run_op(2'd1, 32'h8000_0001, 32'h0000_0003, 0, 0);

      // asynchronous reset between edges mid-calculation
      @(negedge CLK);
      start_in = 1'b1; op_in = 2'd2; opA_in = 32'd1000; opB_in = 32'd3;
      repeat (6) @(posedge CLK);
      #3; RSTn = 1'b0;
      #1;
      chk("arst_busy", busy_out, 1'b0);
      chk("arst_stall", stall_out, 1'b0);
      chk("arst_done", done_out, 1'b0);
      chk("arst_result", result_out, 32'd0);
      start_in = 1'b0;
      @(negedge CLK); RSTn = 1'b1;
      count_done(40, seen);
      chk("arst_no_done", seen, 0);

      run_op(2'd3, 32'd12345, 32'd100, 11, 0);

      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         run_op(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 25)) : 0,
                bit'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (only 32 supported).
REQ-002 SHALL have port: CLK  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: RSTn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: EN  in  1  global enable; 0 freezes all state, counter and registers.
REQ-005 SHALL have port: start_in  in  1  EX-stage instruction is an M-extension op; level, held while stalled.
REQ-006 SHALL have port: op_in  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
REQ-007 SHALL have port: opA_in  in  XLEN  forwarded RS1 value (multiplicand/dividend).
REQ-008 SHALL have port: opB_in  in  XLEN  forwarded RS2 value (multiplier/divisor).
REQ-009 SHALL have port: flush_in  in  1  EX-stage flush (branch/jump taken); aborts operation.
REQ-010 SHALL have port: stall_out  out  1  freezes IF/ID/EX pipeline registers.
REQ-011 SHALL have port: busy_out  out  1  high in CALC.
REQ-012 SHALL have port: done_out  out  1  one-cycle result-valid strobe.
REQ-013 SHALL have port: result_out  out  XLEN  result; valid only while done_out=1.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; all transitions gated by EN=1 except reset.
REQ-015 IDLE: start_in=1 and flush_in=0 SHALL latch op_in/opA_in/opB_in, clear 6-bit counter, go to CALC.
REQ-016 IDLE with DIVU/REMU and opB_in=0 SHALL go directly to DONE (no CALC).
REQ-017 CALC: each edge SHALL perform one iteration (shift-add multiply or restoring divide step), counter+1; edge with counter=31 SHALL go to DONE.
REQ-018 DONE: SHALL assert done_out and drive result for one cycle, then go to IDLE unconditionally; start_in SHALL be ignored in DONE.
REQ-019 Latency: accept edge E0, iteration edges E1..E32, done_out high in the cycle after E32, IDLE after E33.
REQ-020 Multiply SHALL be unsigned 32x32->64; MUL returns bits[31:0], MULHU bits[63:32].
REQ-021 DIVU SHALL return unsigned quotient, REMU unsigned remainder.
REQ-022 Divide by zero: DIVU SHALL return 0xFFFFFFFF; REMU SHALL return opA_in.
REQ-023 stall_out SHALL equal (state=IDLE and start_in and not flush_in) or state=CALC; 0 in DONE.
REQ-024 flush_in=1 SHALL force IDLE at the next edge from any state and suppress done_out; flush has priority over start and completion.
REQ-025 EN=0 SHALL hold state, counter and result; done_out SHALL stay asserted while frozen in DONE.
REQ-026 result_out SHALL be 0 when done_out=0.

Reset
REQ-027 RSTn=0 SHALL immediately force IDLE, counter=0, internal registers=0, stall_out=0, busy_out=0, done_out=0, result_out=0, regardless of CLK.
REQ-028 Reset asserted mid-CALC SHALL discard the operation; after release, no done_out until a new start is accepted.

Verification
REQ-029 MUL 7x6, start held -> stall_out 1 for E0..E32, done_out 1 one cycle after E32, result_out=0x0000002A.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> done after 33 cycles, result_out=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-031 DIVU 100/7 -> result_out=0x0000000E; REMU 100/7 -> 0x00000002; both with done after E32.
REQ-032 DIVU 0x1234/0 -> DONE after E0, result_out=0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234; busy_out never 1.
REQ-033 flush_in=1 at cycle 10 of CALC -> IDLE next edge, stall_out 0, no done_out; next start completes normally.
REQ-034 RSTn pulsed low mid-CALC (between edges) -> outputs 0 asynchronously; EN=0 for 5 cycles mid-CALC -> done delayed exactly 5 cycles, correct result.
